// File: rtl/icache_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : icache_fetch_pkg
// Purpose : Shared types and constants for the instruction-fetch stage:
//           FSM state encodings, instruction width and the canonical NOP.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package icache_fetch_pkg;

    localparam int INST_W = 32;

    // addi x0, x0, 0 -- kept for bubble insertion by later pipeline work
    localparam logic [INST_W-1:0] NOP = 32'h00000013;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_MISS = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
// Module  : icache_array
// Purpose : Direct-mapped storage of 2**IDX_W lines, each {valid, tag, data}.
//           Asynchronous read port, synchronous write port, synchronous
//           invalidate-all on reset (only the valid bits are cleared).
// Ports   : clk, rst                     clock / sync active-high reset
//           i_rd_idx -> o_rd_valid/o_rd_tag/o_rd_data   async lookup
//           i_we, i_wr_idx, i_wr_tag, i_wr_data          line fill
// Revision: 1.0 - initial release
// ============================================================================
module icache_array
    import icache_fetch_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [INST_W-1:0] o_rd_data,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [INST_W-1:0] i_wr_data
);

    localparam int LINES = 2 ** IDX_W;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [INST_W-1:0] r_data [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only ever read through its valid bit.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache_fetch.sv
`default_nettype none
// ============================================================================
// Module  : icache_fetch
// Purpose : Instruction-fetch stage with a direct-mapped, one-word-per-line
//           instruction cache. Zero-cycle hit latency from the registered PC;
//           on a miss a single word fetch is issued to memctrl and the line
//           is filled from its reply.
// Ports   : clk_in, rst_in, rdy_in        clock, sync reset, global ready
//           clear, clear_pc               pipeline flush and redirect target
//           dec_stall                     decoder back-pressure
//           inst_valid, inst_out, inst_pc to decoder
//           mem_if_enable, mem_inst_addr  fetch request to memctrl
//           mem_if_ready, mem_inst        fetch reply from memctrl
// Revision: 1.0 - initial release
// ============================================================================
module icache_fetch
    import icache_fetch_pkg::*;
#(
    parameter int          IDX_W    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic [31:0]       clear_pc,
    input  logic              dec_stall,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_out,
    output logic [31:0]       inst_pc,
    output logic              mem_if_enable,
    output logic [31:0]       mem_inst_addr,
    input  logic              mem_if_ready,
    input  logic [INST_W-1:0] mem_inst
);

    localparam int TAG_W = 30 - IDX_W;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_if_en, w_if_en_nxt;
    logic [31:0] r_addr, w_addr_nxt;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_rd_valid;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [INST_W-1:0] w_rd_data;
    logic              w_hit;
    logic              w_fill;
    logic              w_inst_valid;
    logic [1:0]        w_unused_clear_lsb;

    assign w_idx = r_pc[IDX_W+1:2];
    assign w_tag = r_pc[31:IDX_W+2];
    assign w_hit = w_rd_valid && (w_rd_tag == w_tag);

    // A reply arriving under flush or freeze is dropped, never written.
    assign w_fill = !rst_in && rdy_in && !clear &&
                    (r_state == ST_MISS) && mem_if_ready;

    // Redirect targets are forced word-aligned.
    assign w_unused_clear_lsb = clear_pc[1:0];

    icache_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk        (clk_in),
        .rst        (rst_in),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_we       (w_fill),
        .i_wr_idx   (w_idx),
        .i_wr_tag   (w_tag),
        .i_wr_data  (mem_inst)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_if_en <= 1'b0;
            r_addr  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_if_en <= w_if_en_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_if_en_nxt  = r_if_en;
        w_addr_nxt   = r_addr;
        w_inst_valid = 1'b0;
        // rdy_in low holds every register and suppresses the output.
        if (rdy_in && !rst_in) begin
            if (clear) begin
                w_state_nxt = ST_RUN;
                w_pc_nxt    = {clear_pc[31:2], 2'b00};
                w_if_en_nxt = 1'b0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_hit) begin
                            w_inst_valid = 1'b1;
                            if (!dec_stall) begin
                                w_pc_nxt = r_pc + 32'd4;
                            end
                        end else begin
                            w_addr_nxt  = {r_pc[31:2], 2'b00};
                            w_if_en_nxt = 1'b1;
                            w_state_nxt = ST_MISS;
                        end
                    end
                    ST_MISS: begin
                        if (mem_if_ready) begin
                            w_if_en_nxt = 1'b0;
                            w_state_nxt = ST_RUN;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_RUN;
                    end
                endcase
            end
        end
    end

    assign inst_valid    = w_inst_valid;
    assign inst_out      = w_inst_valid ? w_rd_data : '0;
    assign inst_pc       = r_pc;
    assign mem_if_enable = r_if_en;
    assign mem_inst_addr = r_addr;

endmodule
`default_nettype wire
